// File: rtl/idct_pkg.sv
// Shared constants for the 8x8 inverse DCT: basis table, widths, rounding and clamp limits.
// The state enum covers the IDLE/ROW/COL/DONE sequence of idct_2d.
package idct_pkg;

  localparam int BLOCK_SIZE  = 8;
  localparam int COEF_WIDTH  = 16;
  localparam int TMP_WIDTH   = 24;
  localparam int BASIS_WIDTH = 10;
  localparam int PIX_WIDTH   = 9;
  localparam int ACC_WIDTH   = 37;
  localparam int ROW_SHIFT   = 4;
  localparam int COL_SHIFT   = 12;

  localparam logic signed [ACC_WIDTH-1:0] ROW_RND      = ACC_WIDTH'(8);
  localparam logic signed [ACC_WIDTH-1:0] COL_RND      = ACC_WIDTH'(2048);
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX      = ACC_WIDTH'(255);
  localparam logic signed [ACC_WIDTH-1:0] PIX_MIN      = ACC_WIDTH'(-256);
  localparam logic signed [ACC_WIDTH-1:0] UPIX_MIN     = ACC_WIDTH'(0);
  localparam logic signed [ACC_WIDTH-1:0] LEVEL_OFFSET = ACC_WIDTH'(128);

  // BASIS[x][u] = round(256 * alpha_u * cos((2x+1) u pi / 16)), Q1.8
  localparam int BASIS [BLOCK_SIZE][BLOCK_SIZE] = '{
    '{91,  126,  118,  106,  91,   71,   49,   25},
    '{91,  106,  49,   -25,  -91,  -126, -118, -71},
    '{91,  71,   -49,  -126, -91,  25,   118,  106},
    '{91,  25,   -118, -71,  91,   106,  -49,  -126},
    '{91,  -25,  -118, 71,   91,   -106, -49,  126},
    '{91,  -71,  -49,  126,  -91,  -25,  118,  -106},
    '{91,  -106, 49,   25,   -91,  126,  -118, 71},
    '{91,  -126, 118,  -106, 91,   -71,  49,   -25}
  };

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

  function automatic logic signed [PIX_WIDTH-1:0] sat_pix(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic signed [ACC_WIDTH-1:0] lo,
    input logic signed [ACC_WIDTH-1:0] hi
  );
    if (v > hi) return PIX_WIDTH'(hi);
    if (v < lo) return PIX_WIDTH'(lo);
    return PIX_WIDTH'(v);
  endfunction

endpackage

// File: rtl/idct_mac8.sv
// Combinational 8-term signed dot product; shared by the row and column passes.
module idct_mac8 #(
  parameter int A_W = 10,
  parameter int B_W = 24,
  parameter int S_W = 37
) (
  input  logic signed [A_W-1:0] i_a [8],
  input  logic signed [B_W-1:0] i_b [8],
  output logic signed [S_W-1:0] o_sum
);

  logic signed [A_W+B_W-1:0] w_prod [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_prod
    assign w_prod[gi] = (A_W+B_W)'(i_a[gi]) * (A_W+B_W)'(i_b[gi]);
  end

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < 8; i++) begin
      o_sum = o_sum + S_W'(w_prod[i]);
    end
  end

endmodule

// File: rtl/idct_2d.sv
// 8x8 separable inverse DCT: 64-cycle row pass, 64-cycle column pass, one MAC8 per cycle.
// Define IDCT_LEVEL_SHIFT_EN to add +128 and clamp pixels to [0,255] instead of [-256,255].
module idct_2d
  import idct_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start_block,
  input  logic signed [COEF_WIDTH-1:0] i_coef_block [8][8],
  output logic                        o_busy,
  output logic                        o_block_done,
  output logic signed [PIX_WIDTH-1:0] o_pix_block_out [8][8]
);

  state_t                       r_state;
  state_t                       w_state_next;
  logic [5:0]                   r_idx;
  logic signed [COEF_WIDTH-1:0] r_coef_q [8][8];
  logic signed [TMP_WIDTH-1:0]  r_tmp [8][8];
  logic signed [PIX_WIDTH-1:0]  r_pix_q [8][8];

  logic [2:0]                    w_x;
  logic [2:0]                    w_lo;
  logic signed [BASIS_WIDTH-1:0] w_a [8];
  logic signed [TMP_WIDTH-1:0]   w_b [8];
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [TMP_WIDTH-1:0]   w_tmp_val;
  logic signed [ACC_WIDTH-1:0]   w_col_p;
  logic signed [PIX_WIDTH-1:0]   w_pix_val;

  assign w_x  = r_idx[5:3];
  assign w_lo = r_idx[2:0];

  // ROW: a[u]=B[x][u], b[u]=coef[u][v].  COL: a[v]=B[y][v], b[v]=tmp[x][v].
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_a[i] = BASIS_WIDTH'(BASIS[w_x][i]);
      w_b[i] = TMP_WIDTH'(r_coef_q[i][w_lo]);
      if (r_state == COL) begin
        w_a[i] = BASIS_WIDTH'(BASIS[w_lo][i]);
        w_b[i] = r_tmp[w_x][i];
      end
    end
  end

  idct_mac8 #(
    .A_W (BASIS_WIDTH),
    .B_W (TMP_WIDTH),
    .S_W (ACC_WIDTH)
  ) u_mac (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  assign w_tmp_val = TMP_WIDTH'((w_sum + ROW_RND) >>> ROW_SHIFT);
  assign w_col_p   = (w_sum + COL_RND) >>> COL_SHIFT;

`ifdef IDCT_LEVEL_SHIFT_EN
  assign w_pix_val = sat_pix(w_col_p + LEVEL_OFFSET, UPIX_MIN, PIX_MAX);
`else
  assign w_pix_val = sat_pix(w_col_p, PIX_MIN, PIX_MAX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = (r_state != IDLE);
    o_block_done = (r_state == DONE);
    case (r_state)
      IDLE:    if (i_start_block) w_state_next = ROW;
      ROW:     if (r_idx == 6'd63) w_state_next = COL;
      COL:     if (r_idx == 6'd63) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx           <= '0;
      r_coef_q        <= '{default: '0};
      r_tmp           <= '{default: '0};
      r_pix_q         <= '{default: '0};
      o_pix_block_out <= '{default: '0};
    end else begin
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (i_start_block) r_coef_q <= i_coef_block;
        end
        ROW: begin
          r_idx            <= r_idx + 6'd1;
          r_tmp[w_x][w_lo] <= w_tmp_val;
        end
        COL: begin
          r_idx              <= r_idx + 6'd1;
          r_pix_q[w_x][w_lo] <= w_pix_val;
          // Load the output on the last COL edge, bypassing the final pixel,
          // so the whole block appears in the same cycle block_done is high.
          if (r_idx == 6'd63) begin
            o_pix_block_out       <= r_pix_q;
            o_pix_block_out[7][7] <= w_pix_val;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

endmodule
